pipeline_stall_sequencer: RTL

- Central hazard and stall sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage register write enables, the ID/EX bubble and the IF/ID flush for four hazard sources:
  - load-use
  - multi-cycle data-memory access
  - multi-cycle multiply/divide unit with HI/LO read interlock
  - taken branch
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_sequencer_if.sv | 39 +++
 rtl/pipeline_stall_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard inputs and stage-control outputs of the pipeline stall sequencer.
// The sequencer binds to the slave side; the datapath/hazard sources drive the master side.
interface pipeline_stall_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_md_read;
    logic             ex_md_start;
    logic             mem_req;
    logic             mem_ready;
    logic             ex_branch_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             memwb_we;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             md_busy;
    logic [CNT_W-1:0] stall_count;

    modport slave (
        input  ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, id_md_read,
               ex_md_start, mem_req, mem_ready, ex_branch_taken,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               idex_bubble, ifid_flush, md_busy, stall_count
    );

    modport master (
        output ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, id_md_read,
               ex_md_start, mem_req, mem_ready, ex_branch_taken,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               idex_bubble, ifid_flush, md_busy, stall_count
    );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Hazard/stall sequencer for a 5-stage pipeline: stage write enables, bubble and flush.
// Mealy decode (zero-cycle latency); a data-memory wait freezes every stage until mem_ready.
module pipeline_stall_sequencer #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 16
) (
    input logic                       clk,
    input logic                       reset_n,
    pipeline_stall_sequencer_if.slave bus
);
    typedef enum logic {RUN, MEM_WAIT} stateT;

    localparam logic [4:0] MD_LOAD = 5'(MD_CYCLES);

    stateT            state;
    stateT            stateNext;
    logic [4:0]       mdCnt;
    logic [4:0]       mdCntNext;
    logic [CNT_W-1:0] stallCnt;

    logic freeze;
    logic mdBusy;
    logic loadUse;
    logic mdStartBlock;
    logic mdReadBlock;
    logic pcWe, ifidWe, idexWe, exmemWe, memwbWe, bubble, flush;

    always_comb begin
        freeze       = !bus.mem_ready && ((state == MEM_WAIT) || bus.mem_req);
        mdBusy       = (mdCnt != 5'd0);
        loadUse      = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                       ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        mdStartBlock = mdBusy && bus.ex_md_start && (mdCnt > 5'd1);
        mdReadBlock  = mdBusy && bus.id_md_read;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = RUN;
        pcWe      = 1'b1;
        ifidWe    = 1'b1;
        idexWe    = 1'b1;
        exmemWe   = 1'b1;
        memwbWe   = 1'b1;
        bubble    = 1'b0;
        flush     = 1'b0;
        if (freeze) begin
            stateNext = MEM_WAIT;
            pcWe      = 1'b0;
            ifidWe    = 1'b0;
            idexWe    = 1'b0;
            exmemWe   = 1'b0;
            memwbWe   = 1'b0;
        end else if (bus.ex_branch_taken) begin
            // ID instruction is squashed, so its load-use / HI-LO hazards are moot.
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (loadUse) begin
            pcWe   = 1'b0;
            ifidWe = 1'b0;
            bubble = 1'b1;
        end else if (mdStartBlock) begin
            // Hold the new mult/div in EX; the datapath masks its start while held.
            pcWe   = 1'b0;
            ifidWe = 1'b0;
            idexWe = 1'b0;
        end else if (mdReadBlock) begin
            pcWe   = 1'b0;
            ifidWe = 1'b0;
            bubble = 1'b1;
        end
    end

    // The mult/div unit keeps counting through a memory freeze; only new starts wait.
    always_comb begin
        mdCntNext = mdCnt;
        if (bus.ex_md_start && (mdCnt <= 5'd1) && !freeze) begin
            mdCntNext = MD_LOAD;
        end else if (mdBusy) begin
            mdCntNext = mdCnt - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdCnt    <= 5'd0;
            stallCnt <= '0;
        end else begin
            mdCnt <= mdCntNext;
            if (!pcWe && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign bus.pc_we       = pcWe    & reset_n;
    assign bus.ifid_we     = ifidWe  & reset_n;
    assign bus.idex_we     = idexWe  & reset_n;
    assign bus.exmem_we    = exmemWe & reset_n;
    assign bus.memwb_we    = memwbWe & reset_n;
    assign bus.idex_bubble = bubble  & reset_n;
    assign bus.ifid_flush  = flush   & reset_n;
    assign bus.md_busy     = mdBusy  & reset_n;
    assign bus.stall_count = stallCnt;
endmodule
